dfifo_flow: RTL
===============

Name: dfifo_flow

Overview:
- Synchronous FIFO stage directly upstream of the flow-control block (dfcontrol).
- Buffers data words and generates the occupancy/status flags dfcontrol consumes: almost_full, almost_empty, fifo_empty, fifo_full, fifo_error, fifo_pause.
- Accepts the write/read strobes dfcontrol produces as push/pop.

Parameters:
DATA_WIDTH, 6, width of each stored word
ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH (8)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL
PAUSE_HI, 6, fifo_pause sets when count >= PAUSE_HI
PAUSE_LO, 3, fifo_pause clears when count <= PAUSE_LO (PAUSE_LO < PAUSE_HI)

Ports:
clk  input  1  single clock, all state on posedge
reset  input  1  asynchronous, active-low; 0 = reset asserted
push  input  1  write strobe (dfcontrol write)
pop  input  1  read strobe (dfcontrol read)
data_in  input  DATA_WIDTH  word written on push
data_out  output  DATA_WIDTH  registered head word, valid the cycle after pop
fifo_empty  output  1  count == 0
fifo_full  output  1  count == 2**ADDR_WIDTH
almost_empty  output  1  count <= AE_LEVEL
almost_full  output  1  count >= AF_LEVEL
fifo_pause  output  1  hysteresis backpressure flag
fifo_error  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (reset == 0, asynchronous):
  - wr_ptr, rd_ptr and count clear to 0; data_out = 0.
  - fifo_empty = 1, almost_empty = 1; fifo_full, almost_full, fifo_pause and fifo_error = 0.
  - Memory contents need not be cleared.
  - Reset mid-operation discards all stored words.
- count is ADDR_WIDTH+1 bits. Pointers wrap modulo 2**ADDR_WIDTH with no special handling.
- Push accepted when !fifo_full, or when fifo_full with pop in the same cycle: mem[wr_ptr] <= data_in, wr_ptr++.
- Pop accepted when !fifo_empty: data_out <= mem[rd_ptr], rd_ptr++.
  - Read latency is 1 cycle.
  - data_out holds its value when there is no accepted pop.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with push+pop in the same cycle: both are performed, count stays at depth, no error.
- Empty with push+pop in the same cycle: the pop is an underflow (not performed; data_out holds), the push is accepted, count becomes 1, fifo_error sets.
- Overflow: push while full without pop. Write is dropped, fifo_error sets.
- fifo_error is sticky until reset (see Optional Feature).
- fifo_empty, fifo_full, almost_empty and almost_full are combinational decodes of the count register. They reflect a push/pop one cycle after the strobe edge.
- fifo_pause is a registered 2-state machine:
  - RUN (fifo_pause = 0) -> PAUSE when next count >= PAUSE_HI.
  - PAUSE (fifo_pause = 1) -> RUN when next count <= PAUSE_LO.
  - Otherwise it holds its state.
  - It updates on the same edge as count.
- Flags and data_out are never X after reset.

Optional Feature:
- Macro: DFIFO_ERR_CLR_EN.
- Defined:
  - Adds input port error_clr (1 bit), placed after pop.
  - error_clr == 1 clears fifo_error on the next posedge.
  - If an overflow or underflow occurs in the same cycle as error_clr, set wins and fifo_error = 1.
- Undefined:
  - No error_clr port.
  - fifo_error clears only by reset.

Test Plan:
- Reset then idle: hold reset = 0 for 3 cycles, release -> fifo_empty = 1, almost_empty = 1, all other flags 0, data_out = 0.
- Fill: push 8 words 0x01..0x08 on consecutive cycles -> almost_empty drops after the 3rd push; almost_full and fifo_pause rise after the 6th; fifo_full = 1 after the 8th; count = 8.
- Drain: pop 8 times from full -> data_out = 0x01..0x08 each 1 cycle after its pop. fifo_pause stays 1 until count = 3, then 0. fifo_empty = 1 after the last pop.
- Overflow: full, push 0x3F without pop -> fifo_error = 1, count stays 8; subsequent pops return 0x01..0x08 (0x3F absent).
- Simultaneous: full, push 0x2A + pop -> count = 8, no error, data_out = head. Empty, push 0x15 + pop -> fifo_error = 1, count = 1, the next pop returns 0x15.
- Async reset mid-fill: after 4 pushes, drop reset between clock edges -> flags return to reset values immediately without waiting for a clock edge. With DFIFO_ERR_CLR_EN: a pulse on error_clr after an overflow clears fifo_error next cycle.

Source files
------------

// File: rtl/dfifo_flow_if.sv
// -----------------------------------------------------------------------------
// dfifo_flow_if
// Bundles the push/pop strobes, data buses and status flags exchanged between
// dfifo_flow and its neighbours (dfcontrol on the strobe side).
//   master : drives push, pop, data_in (and error_clr when DFIFO_ERR_CLR_EN)
//            and observes data_out plus all status flags
//   slave  : the FIFO itself
// Optional macro: DFIFO_ERR_CLR_EN adds the error_clr strobe.
// -----------------------------------------------------------------------------
interface dfifo_flow_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  push;
    logic                  pop;
`ifdef DFIFO_ERR_CLR_EN
    logic                  error_clr;
`endif
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  fifo_pause;
    logic                  fifo_error;

`ifdef DFIFO_ERR_CLR_EN
    modport master (
        output push, pop, error_clr, data_in,
        input  data_out, fifo_empty, fifo_full, almost_empty, almost_full,
               fifo_pause, fifo_error
    );
    modport slave (
        input  push, pop, error_clr, data_in,
        output data_out, fifo_empty, fifo_full, almost_empty, almost_full,
               fifo_pause, fifo_error
    );
`else
    modport master (
        output push, pop, data_in,
        input  data_out, fifo_empty, fifo_full, almost_empty, almost_full,
               fifo_pause, fifo_error
    );
    modport slave (
        input  push, pop, data_in,
        output data_out, fifo_empty, fifo_full, almost_empty, almost_full,
               fifo_pause, fifo_error
    );
`endif
endinterface

// File: rtl/dfifo_flow.sv
// -----------------------------------------------------------------------------
// dfifo_flow
// Synchronous FIFO feeding dfcontrol. Stores DATA_WIDTH-bit words, presents a
// registered head word one cycle after an accepted pop, and produces the
// occupancy flags plus a hysteresis pause flag and a sticky error flag.
// Ports:
//   clk    : single clock, all state on posedge
//   reset  : asynchronous, active-low
//   bus    : dfifo_flow_if.slave (push, pop, data_in, data_out, fifo_empty,
//            fifo_full, almost_empty, almost_full, fifo_pause, fifo_error)
// Optional macro: DFIFO_ERR_CLR_EN adds bus.error_clr, which clears
// fifo_error on the next edge (a same-cycle overflow/underflow still sets it).
// All flags are registered from the next-state count, so they change on the
// same edge as the count register itself.
// -----------------------------------------------------------------------------
module dfifo_flow #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int AE_LEVEL   = 2,
    parameter int AF_LEVEL   = 6,
    parameter int PAUSE_HI   = 6,
    parameter int PAUSE_LO   = 3
) (
    input  logic         clk,
    input  logic         reset,
    dfifo_flow_if.slave  bus
);

    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_ZERO  = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_PHI   = (ADDR_WIDTH + 1)'(PAUSE_HI);
    localparam logic [ADDR_WIDTH:0] C_PLO   = (ADDR_WIDTH + 1)'(PAUSE_LO);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } pause_state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_empty;
    logic                  r_almost_full;
    logic                  r_error;
    pause_state_t          r_state;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_err_evt;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  w_error_nxt;
    pause_state_t          w_state_nxt;

    // Accept/reject decisions and next occupancy, derived from the count register.
    always_comb begin
        w_full    = (r_count == C_DEPTH);
        w_empty   = (r_count == C_ZERO);
        // A push while full is still taken if a pop frees the slot this cycle.
        w_push_ok = bus.push && (!w_full || bus.pop);
        w_pop_ok  = bus.pop && !w_empty;
        // Pop on empty is an underflow even when a push arrives alongside it.
        w_err_evt = (bus.push && w_full && !bus.pop) || (bus.pop && w_empty);
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Sticky error: an error event always wins over a clear request.
    always_comb begin
        w_error_nxt = r_error;
        if (w_err_evt) begin
            w_error_nxt = 1'b1;
`ifdef DFIFO_ERR_CLR_EN
        end else if (bus.error_clr) begin
            w_error_nxt = 1'b0;
`endif
        end else begin
            w_error_nxt = r_error;
        end
    end

    // Pause hysteresis next-state, evaluated on the count being loaded this edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_count_nxt >= C_PHI) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (w_count_nxt <= C_PLO) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Storage array; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // Pointers, count, head word, flags and pause state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_data_out     <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_error        <= 1'b0;
            r_state        <= ST_RUN;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
                r_data_out <= r_mem[r_rd_ptr];
            end
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == C_ZERO);
            r_full         <= (w_count_nxt == C_DEPTH);
            r_almost_empty <= (w_count_nxt <= C_AE);
            r_almost_full  <= (w_count_nxt >= C_AF);
            r_error        <= w_error_nxt;
            r_state        <= w_state_nxt;
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.fifo_empty   = r_empty;
    assign bus.fifo_full    = r_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.fifo_error   = r_error;
    assign bus.fifo_pause   = (r_state == ST_PAUSE);

endmodule
